// File: rtl/display_readback.sv
// Seven-segment readback: captures the six hex buses on request, waits for them
// to hold steady, then decodes each active-low pattern back to a nibble.
module display_readback #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MAX_WAIT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  hex0,
  input  logic [6:0]  hex1,
  input  logic [6:0]  hex2,
  input  logic [6:0]  hex3,
  input  logic [6:0]  hex4,
  input  logic [6:0]  hex5,
  input  logic        sample_req,
  output logic        busy,
  output logic [23:0] data_out,
  output logic        valid,
  output logic [5:0]  digit_err,
  output logic        timeout,
  output logic        error
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] StableLast = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] WaitLast   = CW'(MAX_WAIT - 1);

  typedef enum logic {StIdle, StSettle} state_e;

  state_e        state_q, state_d;
  logic [41:0]   snap_q, snap_d;
  logic [CW-1:0] stable_cnt_q, stable_cnt_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [23:0]   data_q, data_d;
  logic [5:0]    derr_q, derr_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic          error_q, error_d;

  logic [41:0]   hex_in;
  logic [23:0]   dec_data;
  logic [5:0]    dec_err;
  logic          match, done, expired;

  assign hex_in = {hex5, hex4, hex3, hex2, hex1, hex0};

  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10; // error flag in bit 4, nibble 0
    endcase
    return r;
  endfunction

  always_comb begin
    dec_data = '0;
    dec_err  = '0;
    for (int i = 0; i < 6; i++) begin
      logic [4:0] d;
      d               = decode_seg(snap_q[i*7 +: 7]);
      dec_data[i*4 +: 4] = d[3:0];
      dec_err[i]      = d[4];
    end
  end

  assign match   = (hex_in == snap_q);
  assign done    = match && (stable_cnt_q == StableLast);
  assign expired = (wait_cnt_q == WaitLast);

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    stable_cnt_d = stable_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    data_d       = data_q;
    derr_d       = derr_q;
    timeout_d    = timeout_q;
    error_d      = error_q;
    valid_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sample_req) begin
          snap_d       = hex_in;
          stable_cnt_d = '0;
          wait_cnt_d   = '0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (match) begin
          stable_cnt_d = stable_cnt_q + 1'b1;
        end else begin
          snap_d       = hex_in;
          stable_cnt_d = '0;
        end
        // Completion takes priority when both land on the same edge.
        if (done || expired) begin
          data_d    = dec_data;
          derr_d    = dec_err;
          timeout_d = !done;
          error_d   = (|dec_err) | !done;
          valid_d   = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      stable_cnt_q <= '0;
      wait_cnt_q   <= '0;
      data_q       <= '0;
      derr_q       <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      stable_cnt_q <= stable_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      data_q       <= data_d;
      derr_q       <= derr_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      error_q      <= error_d;
    end
  end

  assign busy      = (state_q == StSettle);
  assign data_out  = data_q;
  assign digit_err = derr_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign error     = error_q;

endmodule

// File: tb/tb_display_readback.sv
// Directed bench for display_readback: static values, full alphabet, invalid
// digit, late glitch, timeout and reset mid-capture.
module tb_display_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  hx [6];
  logic        sample_req;
  logic        busy;
  logic [23:0] data_out;
  logic        valid;
  logic [5:0]  digit_err;
  logic        timeout;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  display_readback #(
    .STABLE_CYCLES(4),
    .MAX_WAIT     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hex0      (hx[0]),
    .hex1      (hx[1]),
    .hex2      (hx[2]),
    .hex3      (hx[3]),
    .hex4      (hx[4]),
    .hex5      (hx[5]),
    .sample_req(sample_req),
    .busy      (busy),
    .data_out  (data_out),
    .valid     (valid),
    .digit_err (digit_err),
    .timeout   (timeout),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic set_hex(input logic [23:0] v);
    for (int i = 0; i < 6; i++) hx[i] = enc(v[i*4 +: 4]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request at the next edge (E0); returns just after E0.
  task automatic pulse_req();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  // Advance edge by edge until valid is seen, bounded; k = edge index of completion.
  task automatic wait_valid(input int start, output int k);
    k = start;
    do begin
      tick();
      k++;
    end while (!valid && k < 40);
  endtask

  task automatic check_result(input string tag, input logic [23:0] d, input logic [5:0] de,
                              input logic er, input logic to);
    chk({tag, "_data"}, 32'(data_out), 32'(d));
    chk({tag, "_derr"}, 32'(digit_err), 32'(de));
    chk({tag, "_err"}, 32'(error), 32'(er));
    chk({tag, "_tmo"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    int k;
    int seen;
    rst        = 1'b1;
    sample_req = 1'b0;
    set_hex(24'h000000);
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    check_result("rst", 24'h0, 6'h0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // 1: static value
    set_hex(24'h123456);
    pulse_req();
    chk("t1_busy", 32'(busy), 1);
    wait_valid(0, k);
    chk("t1_latency", 32'(k), 4);
    chk("t1_busy_low", 32'(busy), 0);
    check_result("t1", 24'h123456, 6'h0, 1'b0, 1'b0);
    tick();
    chk("t1_pulse", 32'(valid), 0);
    chk("t1_hold", 32'(data_out), 32'h123456);

    // 2: full alphabet
    set_hex(24'hABCDEF);
    pulse_req();
    wait_valid(0, k);
    chk("t2a_latency", 32'(k), 4);
    chk("t2a_data", 32'(data_out), 32'hABCDEF);
    tick();
    set_hex(24'hDEADBE);
    pulse_req();
    wait_valid(0, k);
    chk("t2b_latency", 32'(k), 4);
    chk("t2b_data", 32'(data_out), 32'hDEADBE);
    tick();

    // 3: blank on hex3
    set_hex(24'h000000);
    hx[3] = 7'h7F;
    pulse_req();
    wait_valid(0, k);
    chk("t3_latency", 32'(k), 4);
    check_result("t3", 24'h000000, 6'b001000, 1'b1, 1'b0);
    tick();

    // 4: hex0 changes between E1 and E2
    set_hex(24'h123450);
    pulse_req();
    tick();
    hx[0] = enc(4'h7);
    wait_valid(1, k);
    chk("t4_latency", 32'(k), 6);
    check_result("t4", 24'h123457, 6'h0, 1'b0, 1'b0);
    tick();

    // 5: hex0 toggles every 2 cycles, MAX_WAIT = 16
    set_hex(24'h5A5A50);
    pulse_req();
    k = 0;
    do begin
      tick();
      k++;
      if (k % 2 == 0) hx[0] = (hx[0] == enc(4'h0)) ? enc(4'h1) : enc(4'h0);
    end while (!valid && k < 40);
    chk("t5_latency", 32'(k), 16);
    chk("t5_tmo", 32'(timeout), 1);
    chk("t5_err", 32'(error), 1);
    chk("t5_derr", 32'(digit_err), 0);
    chk("t5_data_hi", 32'(data_out[23:4]), 32'h5A5A5);
    tick();
    chk("t5_busy_after", 32'(busy), 0);
    chk("t5_pulse", 32'(valid), 0);

    // 6: reset sampled at E2
    set_hex(24'h654321);
    pulse_req();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_valid", 32'(valid), 0);
    check_result("t6", 24'h0, 6'h0, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) seen++;
    end
    chk("t6_no_valid", 32'(seen), 0);
    set_hex(24'h123456);
    pulse_req();
    wait_valid(0, k);
    chk("t6_latency", 32'(k), 4);
    check_result("t6b", 24'h123456, 6'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_readback.md
# display_readback

Seven-segment readback decoder for the I/O subsystem. It samples the six `hex0`..`hex5` segment buses on request, waits for them to settle, and decodes each pattern back to a 4-bit nibble. The result is a reconstructed 24-bit value with per-digit validity flags. It sits beside the display controller, closing the loop on display output for self-check and on-board debug readout.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive matching comparisons required before a result is accepted. Legal range is 1 or more.
- `MAX_WAIT`, default 64: cycles after the request at which capture is abandoned. Must be at least `STABLE_CYCLES`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `hex0`..`hex5` in 7 each: segment buses, active-low, bit0 = a … bit6 = g. `hex0` is the least-significant digit.
- `sample_req` in 1: capture request, sampled on the rising edge.
- `busy` out 1: high while a capture is in progress.
- `data_out` out 24: decoded value, with `hex5` in bits [23:20] down to `hex0` in bits [3:0].
- `valid` out 1: one-cycle pulse when a capture completes.
- `digit_err` out 6: bit i set when `hex`i held an undecodable pattern.
- `timeout` out 1: the last capture ended through `MAX_WAIT`.
- `error` out 1: equals `|digit_err | timeout` for the last capture.

## Operation
Decode table, pattern in hex, [6:0]:
- 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78
- 8 = 00, 9 = 10, A = 08, b = 03, C = 46, d = 21, E = 06, F = 0E
- Any other pattern, including blank 7F, gives nibble 0 and sets the matching `digit_err` bit.

FSM states are IDLE and SETTLE.

IDLE:
- `sample_req` = 1 loads all 42 input bits into the snapshot register.
- Clears `stable_cnt` and `wait_cnt`.
- Moves to SETTLE.

SETTLE, evaluated at each edge:
- `wait_cnt` increments every edge.
- If the inputs equal the snapshot, `stable_cnt` increments.
- If they differ, the snapshot reloads from the inputs and `stable_cnt` clears to 0.
- **Completion:** a match while `stable_cnt == STABLE_CYCLES-1`.
  - Decode the snapshot into `data_out` / `digit_err`.
  - `timeout` <= 0, `valid` <= 1.
  - Go to IDLE.
- **Timeout:** `wait_cnt == MAX_WAIT-1` without completion.
  - Decode the current snapshot.
  - `timeout` <= 1, `valid` <= 1.
  - Go to IDLE.
- If completion and timeout fall on the same edge, completion wins and `timeout` = 0.
- `sample_req` in SETTLE is ignored; it is not queued.

Outputs:
- `busy` = (state == SETTLE).
- `data_out`, `digit_err`, `timeout` and `error` hold their values until the next completion.

Reset:
- `rst` forces state IDLE.
- All outputs go to 0: `data_out` = 0, `digit_err` = 0, `valid` = 0, `timeout` = 0, `error` = 0, `busy` = 0.
- Counters and snapshot clear.
- Reset mid-SETTLE aborts the capture; no `valid` pulse follows.

Width rules: counters are `$clog2(MAX_WAIT+1)` bits wide and never wrap within a capture.

## Timing
- `sample_req` is sampled at edge E0, where the snapshot is taken.
- With static inputs, completion is at edge E(`STABLE_CYCLES`). `valid` is high for the single cycle after that edge.
- `busy` rises after E0 and falls at the completion or timeout edge.
- Each input change restarts the stability count from the edge at which it was seen. A change first seen at edge Ek moves completion to E(k+`STABLE_CYCLES`).
- A timeout fires at edge E(`MAX_WAIT`).
- `sample_req` asserted in the same cycle that `valid` is high is accepted as a new E0 (state is already IDLE).
- `sample_req` held high continuously restarts a capture immediately after each completion.
- `error` updates on the same edge as `valid`.

## Test plan
1. **Static value.** Drive patterns for 0x123456 and pulse `sample_req`.
   - Required: `valid` 4 cycles later, `data_out` = 0x123456, `digit_err` = 0, `error` = 0.
2. **Full alphabet.** Drive 0xABCDEF, then 0xDEADBE.
   - Required: exact 24-bit readback each time, including lowercase b/d; F decodes from 0E.
3. **Invalid digit.** Drive blank 7F on `hex3`, others showing 0x000000.
   - Required: `data_out` = 0x000000, `digit_err` = 6'b001000, `error` = 1, `timeout` = 0.
4. **Late glitch.** Change `hex0` once in the cycle before edge E2, then hold.
   - Required: `valid` after E6, not E4; `data_out` reflects the new `hex0`.
5. **Timeout.** Use `MAX_WAIT` = 16 and toggle `hex0` every 2 cycles.
   - Required: `valid` after E16, `timeout` = 1, `error` = 1, `busy` low afterward.
6. **Reset mid-capture.** Assert `rst` at E2 of a capture.
   - Required: all outputs 0, no `valid` pulse.
   - A new `sample_req` then completes normally.
